fix_checksum_stream: RTL and testbench
======================================

# fix_checksum_stream

Streaming FIX checksum engine, parametrised in bytes per beat. It accumulates the mod-256 byte sum of a message body and captures the three ASCII digits of the received `10=` field. It returns the computed sum (binary and ASCII), the received value, a match flag and a format error through a held result handshake. It sits behind the byte framer and ahead of session validation, which consumes the result handshake.

## Interface

**Parameters**
- `BYTES`, default 1: bytes per input beat; 1, 2, 4 or 8. Byte 0 is `data_i[7:0]` and is first on the wire.
- `W`, default `8*BYTES`: data width. Derived; do not override.

**Ports**
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `data_i`  in  W  message bytes.
- `valid_i`  in  1  beat valid.
- `ready_o`  out  1  beat accepted when `valid_i & ready_o`.
- `sof_i`  in  1  first beat of a message.
- `eof_i`  in  1  last beat of a message.
- `keep_i`  in  BYTES  byte present mask.
- `digit_i`  in  BYTES  byte is a checksum digit (the three bytes after `10=`). Digit bytes are never summed.
- `excl_i`  in  BYTES  byte excluded from the sum (`10=` and the final SOH).
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  result consumed when `res_valid_o & res_ready_i`.
- `res_sum_o`  out  8  computed sum mod 256.
- `res_ascii_o`  out  24  `res_sum_o` as three ASCII decimal digits, hundreds digit in [23:16].
- `res_rx_o`  out  8  received checksum value.
- `res_match_o`  out  1  `res_sum_o == res_rx_o` and no format error.
- `res_fmt_err_o`  out  1  digit field is malformed.
- `abort_cnt_o`  out  16  count of messages restarted by `sof_i` before `eof_i`; saturates at 0xFFFF.

## Operation

- **States:** IDLE, ACCUM, RESULT.
- **IDLE.** `ready_o=1`. An accepted beat with `sof_i=1` clears the accumulator, the digit value and the digit count, processes that beat, then goes to ACCUM. If the same beat has `eof_i=1`, it goes to RESULT instead. Beats without `sof_i` are accepted and dropped.
- **ACCUM.** `ready_o=1`. For each accepted beat:
  - Every byte with `keep & ~excl & ~digit` is added to the accumulator.
  - Every byte with `keep & digit` is folded in byte order: `val = val*10 + (b - 0x30)`, and the digit count increments. The count saturates at 4.
  - On `eof_i`, go to RESULT.
  - On `sof_i` without `eof_i` on the same beat: `abort_cnt_o` increments, all per-message state restarts from this beat, and the state stays ACCUM.
- **Arithmetic.**
  - Each beat's partial sum is `8+clog2(BYTES)` bits wide.
  - The accumulator is 8 bits, and every update is truncated mod 256.
  - The digit value is 10 bits and saturates at 1023.
- **Format error.** Set when any of the following holds:
  - the digit count is not exactly 3;
  - any digit byte lies outside 0x30–0x39;
  - the value exceeds 255.
- **Received value.** `res_rx_o` is the low 8 bits of the digit value, or 0 when there is a format error.
- **RESULT.**
  - `ready_o=0` and `res_valid_o=1`.
  - All `res_*` outputs are stable until the handshake completes.
  - On `res_ready_i=1`, go to IDLE.
- **Reset.** Every output is 0 and the state is IDLE. Reset mid-message or mid-RESULT discards all state without producing a result.

## Timing

- **Latency.** The `eof_i` beat is accepted in cycle N. `res_valid_o` rises in N+1 with all fields valid.
- **Back-to-back messages.** The result is accepted in cycle M, `ready_o` rises in M+1, and the next `sof_i` beat can be accepted in M+1. Throughput is one message per (beats + 1) cycles when `res_ready_i` is held high.
- **Output timing.** `ready_o` and `res_valid_o` are registered state decodes; there is no combinational path from `valid_i` to `ready_o`.
- **ASCII conversion.** `res_ascii_o` is registered in the same cycle as `res_sum_o`.

## Structure

- **Package `fix_pkg`** holds:
  - constants `ASCII_0 = 8'h30`, `ASCII_9 = 8'h39`, `SOH = 8'h01`;
  - the state enum `cs_state_t`;
  - the struct `cs_result_t` containing sum, ascii, rx, match and fmt_err.
- **Sub-module `fix_bin2dec`:** combinational conversion from an 8-bit value to 24-bit ASCII, using subtract-compare at 200/100 then 10. It is reused by the checksum generator on the transmit path.

## Test plan

1. **Basic match.** BYTES=1; beats 0x41, 0x42, 0x43, then `excl` bytes `1`, `0`, `=`, digits `1`, `9`, `8`, and `excl` SOH with `eof`. Required: sum 0xC6, ascii 0x313938, rx 198, match=1, fmt_err=0, `res_valid_o` one cycle after eof.
2. **Wrap-around.** Body 0xFF, 0x02, digits `001`. Required: sum 0x01, ascii 0x303031, match=1.
3. **Malformed digit fields.**
   - Digits `256`: fmt_err=1, rx=0, match=0.
   - Digits `12` only: fmt_err=1.
   - Digits `1A3`: fmt_err=1.
4. **Multi-byte beats.** BYTES=4; `data_i=0x01020304`, keep=4'b0111, excl=0, eof on the following beat with digits `009` and keep=4'b0111. Required: sum 9, match=1. The same beat with keep=4'b1111 gives sum 10 and match=0.
5. **Backpressure.** Hold `res_ready_i=0` for 5 cycles. Required: `ready_o=0`, `res_*` stable; accept, then `ready_o=1` the next cycle, and the following `sof` is accepted.
6. **Abort and reset.**
   - `sof`, body, `sof` again without eof: `abort_cnt_o=1`, and the result reflects only the second message.
   - `rst_n=0` mid-ACCUM: no `res_valid_o`, all outputs 0.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX checksum datapath (receive engine and
// transmit-side generator).
package fix_pkg;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] SOH     = 8'h01;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StResult = 2'd2
    } cs_state_t;

    typedef struct packed {
        logic [7:0]  sum;
        logic [23:0] ascii;
        logic [7:0]  rx;
        logic        match;
        logic        fmt_err;
    } cs_result_t;

endpackage

// File: rtl/fix_bin2dec.sv
// Combinational 8-bit binary to three ASCII decimal digits, hundreds digit in [23:16].
// Shared with the transmit-path checksum generator.
module fix_bin2dec
    import fix_pkg::*;
(
    input  logic [7:0]  bin_i,
    output logic [23:0] ascii_o
);

    logic [7:0] rem_h;
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] units;

    always_comb begin
        hund  = 4'd0;
        rem_h = bin_i;
        if (bin_i >= 8'd200) begin
            hund  = 4'd2;
            rem_h = bin_i - 8'd200;
        end else if (bin_i >= 8'd100) begin
            hund  = 4'd1;
            rem_h = bin_i - 8'd100;
        end

        // Largest multiple of ten not above the remainder.
        tens = 4'd0;
        for (int k = 9; k >= 1; k--) begin
            if (tens == 4'd0 && rem_h >= 8'(10 * k)) begin
                tens = 4'(k);
            end
        end
        units = 4'(rem_h - 8'(tens) * 8'd10);

        ascii_o = {ASCII_0 | {4'h0, hund}, ASCII_0 | {4'h0, tens}, ASCII_0 | {4'h0, units}};
    end

endmodule

// File: rtl/fix_checksum_stream.sv
// Streaming FIX checksum engine: mod-256 sum of the message body plus capture of the
// received 10= digits, returned through a held valid/ready result handshake.
module fix_checksum_stream
    import fix_pkg::*;
#(
    parameter int unsigned BYTES = 1,
    parameter int unsigned W     = 8 * BYTES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             sof_i,
    input  logic             eof_i,
    input  logic [BYTES-1:0] keep_i,
    input  logic [BYTES-1:0] digit_i,
    input  logic [BYTES-1:0] excl_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [7:0]       res_sum_o,
    output logic [23:0]      res_ascii_o,
    output logic [7:0]       res_rx_o,
    output logic             res_match_o,
    output logic             res_fmt_err_o,
    output logic [15:0]      abort_cnt_o
);

    localparam int unsigned PW     = 8 + $clog2(BYTES);
    localparam logic [2:0]  MaxCnt = 3'd4;
    localparam logic [9:0]  MaxVal = 10'd1023;

    cs_state_t   state_q, state_d;
    logic [7:0]  acc_q, acc_d;
    logic [9:0]  val_q, val_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        bad_q, bad_d;
    logic [15:0] abort_q, abort_d;
    cs_result_t  res_q, res_d;
    logic        ready_q;
    logic        res_valid_q;

    logic        beat_acc;
    logic        take;
    logic [PW-1:0] part;
    logic [7:0]  byte_v;
    logic [13:0] prod;
    logic [7:0]  acc_base;
    logic [7:0]  acc_nx;
    logic [9:0]  val_nx;
    logic [2:0]  cnt_nx;
    logic        bad_nx;
    logic        fmt_nx;
    logic [7:0]  rx_nx;
    logic [23:0] ascii_nx;
    cs_result_t  res_nx;

    assign beat_acc = valid_i & ready_q;

    // A sof beat starts from cleared per-message state; otherwise continue the message.
    always_comb begin
        acc_base = sof_i ? 8'd0 : acc_q;
        val_nx   = sof_i ? 10'd0 : val_q;
        cnt_nx   = sof_i ? 3'd0 : cnt_q;
        bad_nx   = sof_i ? 1'b0 : bad_q;
        part     = '0;
        byte_v   = '0;
        prod     = '0;
        for (int i = 0; i < BYTES; i++) begin
            byte_v = data_i[8*i +: 8];
            if (keep_i[i] && !excl_i[i] && !digit_i[i]) begin
                part = part + PW'(byte_v);
            end
            if (keep_i[i] && digit_i[i]) begin
                prod   = 14'(val_nx) * 14'd10 + 14'(byte_v - ASCII_0);
                val_nx = (prod > 14'(MaxVal)) ? MaxVal : prod[9:0];
                if (byte_v < ASCII_0 || byte_v > ASCII_9) begin
                    bad_nx = 1'b1;
                end
                if (cnt_nx != MaxCnt) begin
                    cnt_nx = cnt_nx + 3'd1;
                end
            end
        end
        acc_nx = 8'(PW'(acc_base) + part);
    end

    fix_bin2dec u_bin2dec (
        .bin_i   (acc_nx),
        .ascii_o (ascii_nx)
    );

    always_comb begin
        fmt_nx          = (cnt_nx != 3'd3) || bad_nx || (val_nx > 10'd255);
        rx_nx           = fmt_nx ? 8'd0 : val_nx[7:0];
        res_nx.sum      = acc_nx;
        res_nx.ascii    = ascii_nx;
        res_nx.rx       = rx_nx;
        res_nx.match    = !fmt_nx && (acc_nx == rx_nx);
        res_nx.fmt_err  = fmt_nx;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        abort_d = abort_q;
        res_d   = res_q;
        take    = 1'b0;

        unique case (state_q)
            StIdle: begin
                take = beat_acc & sof_i;
            end
            StAccum: begin
                take = beat_acc;
                if (beat_acc && sof_i && !eof_i && abort_q != 16'hFFFF) begin
                    abort_d = abort_q + 16'd1;
                end
            end
            StResult: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (take) begin
            acc_d = acc_nx;
            val_d = val_nx;
            cnt_d = cnt_nx;
            bad_d = bad_nx;
            if (eof_i) begin
                state_d = StResult;
                res_d   = res_nx;
            end else begin
                state_d = StAccum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            val_q       <= '0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            abort_q     <= '0;
            res_q       <= '0;
            ready_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            val_q       <= val_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            abort_q     <= abort_d;
            res_q       <= res_d;
            ready_q     <= (state_d != StResult);
            res_valid_q <= (state_d == StResult);
        end
    end

    assign ready_o       = ready_q;
    assign res_valid_o   = res_valid_q;
    assign res_sum_o     = res_q.sum;
    assign res_ascii_o   = res_q.ascii;
    assign res_rx_o      = res_q.rx;
    assign res_match_o   = res_q.match;
    assign res_fmt_err_o = res_q.fmt_err;
    assign abort_cnt_o   = abort_q;

endmodule

// File: tb/tb_fix_checksum_stream.sv
// Scoreboard bench for fix_checksum_stream: token-level message model, randomized lane
// packing, result backpressure, aborts and mid-message reset.
module tb_fix_checksum_stream;
    import fix_pkg::*;

    localparam int unsigned BYTES = 4;
    localparam int unsigned W     = 8 * BYTES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [W-1:0]     data_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic             sof_i = 1'b0;
    logic             eof_i = 1'b0;
    logic [BYTES-1:0] keep_i = '0;
    logic [BYTES-1:0] digit_i = '0;
    logic [BYTES-1:0] excl_i = '0;
    logic             res_valid_o;
    logic             res_ready_i = 1'b0;
    logic [7:0]       res_sum_o;
    logic [23:0]      res_ascii_o;
    logic [7:0]       res_rx_o;
    logic             res_match_o;
    logic             res_fmt_err_o;
    logic [15:0]      abort_cnt_o;

    fix_checksum_stream #(.BYTES(BYTES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .sof_i         (sof_i),
        .eof_i         (eof_i),
        .keep_i        (keep_i),
        .digit_i       (digit_i),
        .excl_i        (excl_i),
        .res_valid_o   (res_valid_o),
        .res_ready_i   (res_ready_i),
        .res_sum_o     (res_sum_o),
        .res_ascii_o   (res_ascii_o),
        .res_rx_o      (res_rx_o),
        .res_match_o   (res_match_o),
        .res_fmt_err_o (res_fmt_err_o),
        .abort_cnt_o   (abort_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sum;
        logic [23:0] ascii;
        logic [7:0]  rx;
        logic        match;
        logic        fmt;
        logic [15:0] abort;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] tok_b[$];
    int         tok_k[$];   // 0 body, 1 excluded, 2 digit
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         lat_cyc = -1;
    int         abort_model = 0;
    bit         hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        res_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_res(input exp_t e);
        chk("res_sum", res_sum_o, e.sum);
        chk("res_ascii", res_ascii_o, e.ascii);
        chk("res_rx", res_rx_o, e.rx);
        chk("res_match", res_match_o, e.match);
        chk("res_fmt_err", res_fmt_err_o, e.fmt);
        chk("abort_cnt", abort_cnt_o, e.abort);
    endtask

    // Monitor: pops one expectation per presented result and holds it until the handshake.
    exp_t cur;
    bit   have = 1'b0;
    bit   acc_pend = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            have     = 1'b0;
            acc_pend = 1'b0;
        end else begin
            if (acc_pend) begin
                chk("ready_after_accept", ready_o, 1);
                chk("valid_after_accept", res_valid_o, 0);
                acc_pend = 1'b0;
            end
            if (cyc == lat_cyc) chk("eof_to_valid_latency", res_valid_o, 1);
            if (res_valid_o) begin
                chk("ready_in_result", ready_o, 0);
                if (!have) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got res_valid_o=1, expected no result");
                    end else begin
                        cur  = sb.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) cmp_res(cur);
                if (res_ready_i) begin
                    have     = 1'b0;
                    acc_pend = 1'b1;
                end
            end
        end
    end

    task automatic add(input logic [7:0] b, input int k);
        tok_b.push_back(b);
        tok_k.push_back(k);
    endtask

    task automatic clear_tokens();
        tok_b.delete();
        tok_k.delete();
    endtask

    task automatic add_tag();
        add(8'h31, 1);
        add(8'h30, 1);
        add(8'h3D, 1);
    endtask

    // Reference: checksum rules applied to the token list directly.
    task automatic push_expected();
        int   s = 0;
        int   cnt = 0;
        int   v = 0;
        bit   bad = 0;
        exp_t e;
        foreach (tok_b[i]) begin
            if (tok_k[i] == 0) begin
                s += int'(tok_b[i]);
            end else if (tok_k[i] == 2) begin
                cnt++;
                if (tok_b[i] < 8'h30 || tok_b[i] > 8'h39) bad = 1;
                else v = v * 10 + int'(tok_b[i]) - 48;
            end
        end
        s       = s % 256;
        e.sum   = 8'(s);
        e.ascii = {8'h30 + 8'(s / 100), 8'h30 + 8'((s / 10) % 10), 8'h30 + 8'(s % 10)};
        e.fmt   = (cnt != 3) || bad || (v > 255);
        e.rx    = e.fmt ? 8'd0 : 8'(v);
        e.match = !e.fmt && (e.rx == e.sum);
        e.abort = 16'(abort_model);
        sb.push_back(e);
    endtask

    // Called at a negedge; holds the beat until the DUT is ready, returns at a later negedge.
    task automatic send_beat(input logic [W-1:0] d, input logic [BYTES-1:0] k,
                             input logic [BYTES-1:0] dg, input logic [BYTES-1:0] ex,
                             input logic s, input logic e, input bit real_eof);
        int n = 0;
        data_i  = d;
        keep_i  = k;
        digit_i = dg;
        excl_i  = ex;
        sof_i   = s;
        eof_i   = e;
        valid_i = 1'b1;
        while (ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready_o !== 1'b1) chk("beat_accept_timeout", ready_o, 1);
        else if (real_eof) lat_cyc = cyc + 1;
        @(negedge clk);
        valid_i = 1'b0;
        sof_i   = 1'b0;
        eof_i   = 1'b0;
    endtask

    task automatic send_prefix();
        int nb = $urandom_range(1, 3);
        for (int i = 0; i < nb; i++) begin
            send_beat($urandom, 4'($urandom), 4'($urandom), 4'($urandom), (i == 0), 1'b0, 0);
        end
    endtask

    // pack=0: random lane placement of 1..4 bytes per beat; pack>0: fixed bytes from lane 0.
    task automatic send_msg(input int pack, input bit prefix, input bit junk);
        int idx = 0;
        int n;
        int rem;
        bit first = 1;
        logic [W-1:0]     d;
        logic [BYTES-1:0] k;
        logic [BYTES-1:0] dg;
        logic [BYTES-1:0] ex;
        if (junk) send_beat($urandom, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0,
                            1'($urandom), 0);
        if (prefix) begin
            send_prefix();
            if (abort_model < 65535) abort_model++;
        end
        push_expected();
        while (idx < tok_b.size()) begin
            rem = tok_b.size() - idx;
            if (pack > 0) begin
                n = (pack < rem) ? pack : rem;
                k = 4'((1 << n) - 1);
            end else begin
                n = $urandom_range(1, (rem < 4) ? rem : 4);
                do k = 4'($urandom); while ($countones(k) != n);
            end
            d  = $urandom;
            dg = 4'($urandom);
            ex = 4'($urandom);
            for (int l = 0; l < BYTES; l++) begin
                if (k[l]) begin
                    d[8*l +: 8] = tok_b[idx];
                    dg[l]       = (tok_k[idx] == 2);
                    ex[l]       = (tok_k[idx] == 1);
                    idx++;
                end
            end
            send_beat(d, k, dg, ex, first, (idx == tok_b.size()), (idx == tok_b.size()));
            first = 0;
            if ($urandom_range(0, 3) == 0 && idx < tok_b.size()) @(negedge clk);
        end
    endtask

    task automatic gen_random();
        int   nb = $urandom_range(0, 8);
        int   s = 0;
        int   mode = $urandom_range(0, 9);
        int   nd;
        int   badpos;
        logic [7:0] b;
        clear_tokens();
        for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            add(b, 0);
            s += int'(b);
        end
        s = s % 256;
        add_tag();
        if (mode < 6) begin
            add(8'h30 + 8'(s / 100), 2);
            add(8'h30 + 8'((s / 10) % 10), 2);
            add(8'h30 + 8'(s % 10), 2);
        end else if (mode == 6) begin
            for (int i = 0; i < 3; i++) add(8'h30 + 8'($urandom_range(0, 9)), 2);
        end else if (mode == 7) begin
            nd = $urandom_range(0, 3);
            nd = (nd < 2) ? nd + 1 : nd + 2;
            for (int i = 0; i < nd; i++) add(8'h30 + 8'($urandom_range(0, 9)), 2);
        end else begin
            badpos = $urandom_range(0, 2);
            for (int i = 0; i < 3; i++) begin
                if (i == badpos) begin
                    do b = 8'($urandom); while (b >= 8'h30 && b <= 8'h39);
                    add(b, 2);
                end else begin
                    add(8'h30 + 8'($urandom_range(0, 9)), 2);
                end
            end
        end
        add(SOH, 1);
    endtask

    task automatic digits3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        add(a, 2);
        add(b, 2);
        add(c, 2);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || res_valid_o) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, ready_o, 0);
        chk({tag, "_valid"}, res_valid_o, 0);
        chk({tag, "_sum"}, res_sum_o, 0);
        chk({tag, "_ascii"}, res_ascii_o, 0);
        chk({tag, "_rx"}, res_rx_o, 0);
        chk({tag, "_match"}, res_match_o, 0);
        chk({tag, "_fmt"}, res_fmt_err_o, 0);
        chk({tag, "_abort"}, abort_cnt_o, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic match, one byte per beat: "ABC" 10=198 SOH.
        clear_tokens();
        add(8'h41, 0); add(8'h42, 0); add(8'h43, 0);
        add_tag();
        digits3(8'h31, 8'h39, 8'h38);
        add(SOH, 1);
        send_msg(1, 0, 0);

        // Wrap-around of the mod-256 sum.
        clear_tokens();
        add(8'hFF, 0); add(8'h02, 0);
        digits3(8'h30, 8'h30, 8'h31);
        add(SOH, 1);
        send_msg(1, 0, 0);

        // Malformed digit fields: value > 255, two digits, non-digit byte.
        clear_tokens(); add(8'h10, 0); add_tag(); digits3(8'h32, 8'h35, 8'h36); add(SOH, 1);
        send_msg(0, 0, 0);
        clear_tokens(); add(8'h0C, 0); add_tag(); add(8'h31, 2); add(8'h32, 2); add(SOH, 1);
        send_msg(0, 0, 0);
        clear_tokens(); add_tag(); digits3(8'h31, 8'h41, 8'h33); add(SOH, 1);
        send_msg(0, 0, 0);

        // Multi-byte beats: three then four body bytes of 0x01020304.
        clear_tokens();
        add(8'h04, 0); add(8'h03, 0); add(8'h02, 0);
        digits3(8'h30, 8'h30, 8'h39);
        send_msg(3, 0, 0);
        clear_tokens();
        add(8'h04, 0); add(8'h03, 0); add(8'h02, 0); add(8'h01, 0);
        digits3(8'h30, 8'h30, 8'h39);
        send_msg(4, 0, 0);

        // Single sof+eof beat from idle.
        clear_tokens();
        digits3(8'h30, 8'h30, 8'h30);
        add(SOH, 1);
        send_msg(4, 0, 0);

        // Result backpressure held for five cycles.
        hold_ready = 1'b1;
        gen_random();
        send_msg(0, 0, 0);
        n = 0;
        while (!res_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("bp_valid_held", res_valid_o, 1);
        chk("bp_ready_low", ready_o, 0);
        hold_ready = 1'b0;

        // Abort: restarted message counts once, result covers the second message only.
        gen_random();
        send_msg(0, 1, 0);

        for (int m = 0; m < 40; m++) begin
            gen_random();
            send_msg(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
        end
        drain();

        // Reset in the middle of a message.
        send_prefix();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        abort_model = 0;
        repeat (4) @(negedge clk);
        chk("post_reset_no_valid", res_valid_o, 0);

        gen_random();
        send_msg(0, 0, 0);
        gen_random();
        send_msg(0, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
